// File: rtl/jtag_tap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_tap_pkg
//  Purpose  : TAP state encoding, IR opcodes and the 1149.1 next-state function.
//  Revision : 1.0 - initial release
// ============================================================================
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'h0,
    RunTestIdle    = 4'h1,
    SelectDrScan   = 4'h2,
    CaptureDr      = 4'h3,
    ShiftDr        = 4'h4,
    Exit1Dr        = 4'h5,
    PauseDr        = 4'h6,
    Exit2Dr        = 4'h7,
    UpdateDr       = 4'h8,
    SelectIrScan   = 4'h9,
    CaptureIr      = 4'hA,
    ShiftIr        = 4'hB,
    Exit1Ir        = 4'hC,
    PauseIr        = 4'hD,
    Exit2Ir        = 4'hE,
    UpdateIr       = 4'hF
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE  = 5'h01;
  localparam logic [4:0] IR_DTMCS   = 5'h10;
  localparam logic [4:0] IR_DMI     = 5'h11;
  localparam logic [4:0] IR_BYPASS  = 5'h1F;
  localparam logic [4:0] IR_CAPTURE = 5'h01;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TestLogicReset: n = tms ? TestLogicReset : RunTestIdle;
      RunTestIdle:    n = tms ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   n = tms ? SelectIrScan   : CaptureDr;
      CaptureDr:      n = tms ? Exit1Dr        : ShiftDr;
      ShiftDr:        n = tms ? Exit1Dr        : ShiftDr;
      Exit1Dr:        n = tms ? UpdateDr       : PauseDr;
      PauseDr:        n = tms ? Exit2Dr        : PauseDr;
      Exit2Dr:        n = tms ? UpdateDr       : ShiftDr;
      UpdateDr:       n = tms ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   n = tms ? TestLogicReset : CaptureIr;
      CaptureIr:      n = tms ? Exit1Ir        : ShiftIr;
      ShiftIr:        n = tms ? Exit1Ir        : ShiftIr;
      Exit1Ir:        n = tms ? UpdateIr       : PauseIr;
      PauseIr:        n = tms ? Exit2Ir        : PauseIr;
      Exit2Ir:        n = tms ? UpdateIr       : ShiftIr;
      UpdateIr:       n = tms ? SelectDrScan   : RunTestIdle;
      default:        n = TestLogicReset;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_sync / jtag_sync_edge
//  Purpose  : Multi-flop pin synchroniser, and a 1-bit variant with edge detect.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_sync #(
  parameter int unsigned Width      = 1,
  parameter int unsigned SyncStages = 2
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [SyncStages-1:0][Width-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], d_i};
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) sync_q <= '0;
    else             sync_q <= sync_d;
  end

  assign q_o = sync_q[SyncStages-1];

endmodule

module jtag_sync_edge #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_sys_i,
  input  logic rst_sys_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic                level;
  logic                prev_q, prev_d;
  logic [SyncStages:0] armed_q, armed_d;

  jtag_sync #(.Width(1), .SyncStages(SyncStages)) u_sync (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .d_i        (d_i),
    .q_o        (level)
  );

  // Edges stay masked until prev_q holds a genuine pin sample, so a pin
  // already high at reset release is never mistaken for a rise.
  always_comb begin
    prev_d  = level;
    armed_d = {armed_q[SyncStages-1:0], 1'b1};
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      prev_q  <= 1'b0;
      armed_q <= '0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  assign rise_o = armed_q[SyncStages] &  level & ~prev_q;
  assign fall_o = armed_q[SyncStages] & ~level &  prev_q;

endmodule
`default_nettype wire

// File: rtl/jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_tap_sampled
//  Purpose  : Oversampled JTAG TAP with IR/IDCODE/BYPASS and DTMCS/DMI strobes.
//             Optional JTAG_TAP_TRST_EN makes a low trst_ni force Test-Logic-Reset.
//  Revision : 1.0 - initial release
// ============================================================================
module jtag_tap_sampled
  import jtag_tap_pkg::*;
#(
  parameter int unsigned IrLength    = 5,
  parameter logic [31:0] IdcodeValue = 32'h1000_0CDF,
  parameter int unsigned SyncStages  = 2
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       tck_i,
  input  logic       tms_i,
  input  logic       trst_ni,
  input  logic       td_i,
  output logic       td_o,
  output logic       td_oe_o,
  output logic [3:0] tap_state_o,
  output logic       dtmcs_sel_o,
  output logic       dmi_sel_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o,
  output logic       dr_tdi_o,
  input  logic       dtmcs_tdo_i,
  input  logic       dmi_tdo_i
);

  localparam logic [IrLength-1:0] IrIdcode  = IrLength'(IR_IDCODE);
  localparam logic [IrLength-1:0] IrDtmcs   = IrLength'(IR_DTMCS);
  localparam logic [IrLength-1:0] IrDmi     = IrLength'(IR_DMI);
  localparam logic [IrLength-1:0] IrCapture = IrLength'(IR_CAPTURE);

  tap_state_e          state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_d, ir_shift_q, ir_shift_d;
  logic [31:0]         idcode_q, idcode_d;
  logic                bypass_q, bypass_d;
  logic                td_q, td_d, td_oe_q, td_oe_d;
  logic                capture_q, capture_d, shift_q, shift_d, update_q, update_d;
  logic                dr_tdi_q, dr_tdi_d;

  logic tck_rise, tck_fall, tms_s, tdi_s, trst_n_s, force_tlr;
  logic idcode_sel, dtmcs_sel, dmi_sel, bypass_sel, dr_tdo, rise_ok;

  jtag_sync_edge #(.SyncStages(SyncStages)) u_tck_sync (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .d_i        (tck_i),
    .rise_o     (tck_rise),
    .fall_o     (tck_fall)
  );

  jtag_sync #(.Width(3), .SyncStages(SyncStages)) u_pin_sync (
    .clk_sys_i  (clk_sys_i),
    .rst_sys_ni (rst_sys_ni),
    .d_i        ({tms_i, td_i, trst_ni}),
    .q_o        ({tms_s, tdi_s, trst_n_s})
  );

`ifdef JTAG_TAP_TRST_EN
  assign force_tlr = ~trst_n_s;
`else
  logic unused_trst_n;
  assign unused_trst_n = trst_n_s;
  assign force_tlr     = 1'b0;
`endif

  assign idcode_sel = (ir_q == IrIdcode);
  assign dtmcs_sel  = (ir_q == IrDtmcs);
  assign dmi_sel    = (ir_q == IrDmi);
  assign bypass_sel = ~(idcode_sel | dtmcs_sel | dmi_sel);
  assign dr_tdo     = idcode_sel ? idcode_q[0] :
                      dtmcs_sel  ? dtmcs_tdo_i :
                      dmi_sel    ? dmi_tdo_i   : bypass_q;
  assign rise_ok    = tck_rise & ~force_tlr;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) state_q <= TestLogicReset;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (force_tlr)    state_d = TestLogicReset;
    else if (tck_rise) state_d = tap_next(state_q, tms_s);
  end

  // Shift/update actions key off the state held before the rise.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    idcode_d   = idcode_q;
    bypass_d   = bypass_q;
    td_d       = td_q;
    td_oe_d    = td_oe_q;
    capture_d  = 1'b0;
    shift_d    = 1'b0;
    update_d   = 1'b0;
    dr_tdi_d   = tdi_s;
    if (rise_ok) begin
      case (state_q)
        CaptureIr: ir_shift_d = IrCapture;
        ShiftIr:   ir_shift_d = {tdi_s, ir_shift_q[IrLength-1:1]};
        UpdateIr:  ir_d = ir_shift_q;
        CaptureDr: begin
          capture_d = 1'b1;
          bypass_d  = 1'b0;
          if (idcode_sel) idcode_d = IdcodeValue;
        end
        ShiftDr: begin
          shift_d = 1'b1;
          if (idcode_sel) idcode_d = {tdi_s, idcode_q[31:1]};
          if (bypass_sel) bypass_d = tdi_s;
        end
        UpdateDr:  update_d = 1'b1;
        default:   ;
      endcase
    end
    if (tck_fall) begin
      td_oe_d = (state_q == ShiftIr) || (state_q == ShiftDr);
      if (state_q == ShiftIr)      td_d = ir_shift_q[0];
      else if (state_q == ShiftDr) td_d = dr_tdo;
    end
    if (state_q == TestLogicReset || force_tlr) ir_d = IrIdcode;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      ir_q       <= IrIdcode;
      ir_shift_q <= '0;
      idcode_q   <= '0;
      bypass_q   <= 1'b0;
      td_q       <= 1'b0;
      td_oe_q    <= 1'b0;
      capture_q  <= 1'b0;
      shift_q    <= 1'b0;
      update_q   <= 1'b0;
      dr_tdi_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      idcode_q   <= idcode_d;
      bypass_q   <= bypass_d;
      td_q       <= td_d;
      td_oe_q    <= td_oe_d;
      capture_q  <= capture_d;
      shift_q    <= shift_d;
      update_q   <= update_d;
      dr_tdi_q   <= dr_tdi_d;
    end
  end

  assign td_o         = td_q;
  assign td_oe_o      = td_oe_q;
  assign tap_state_o  = state_q;
  assign dtmcs_sel_o  = dtmcs_sel;
  assign dmi_sel_o    = dmi_sel;
  assign capture_dr_o = capture_q;
  assign shift_dr_o   = shift_q;
  assign update_dr_o  = update_q;
  assign dr_tdi_o     = dr_tdi_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_sampled.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_tap_sampled
//  Purpose  : Directed self-checking bench for jtag_tap_sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_sampled;

  localparam int SYNC = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic tck = 1'b0, tms = 1'b1, trst_n = 1'b1, tdi = 1'b0;
  logic dtmcs_tdo = 1'b0, dmi_tdo = 1'b0;
  logic td_o, td_oe, dtmcs_sel, dmi_sel, cap_dr, shf_dr, upd_dr, dr_tdi;
  logic [3:0] state;

  int checks = 0, errors = 0;
  int cap_cnt = 0, shift_cnt = 0, upd_cnt = 0, tdi_bad = 0;

  jtag_tap_sampled dut (
    .clk_sys_i    (clk),
    .rst_sys_ni   (rst_n),
    .tck_i        (tck),
    .tms_i        (tms),
    .trst_ni      (trst_n),
    .td_i         (tdi),
    .td_o         (td_o),
    .td_oe_o      (td_oe),
    .tap_state_o  (state),
    .dtmcs_sel_o  (dtmcs_sel),
    .dmi_sel_o    (dmi_sel),
    .capture_dr_o (cap_dr),
    .shift_dr_o   (shf_dr),
    .update_dr_o  (upd_dr),
    .dr_tdi_o     (dr_tdi),
    .dtmcs_tdo_i  (dtmcs_tdo),
    .dmi_tdo_i    (dmi_tdo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_dr) cap_cnt++;
    if (upd_dr) upd_cnt++;
    if (shf_dr) begin
      shift_cnt++;
      if (dr_tdi !== tdi) tdi_bad++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full tck period: tms/tdi set while tck is low, high 5 clk, low 7 clk.
  task automatic tck_step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    wait_clk(2);
    tck = 1'b1;
    wait_clk(5);
    tck = 1'b0;
    wait_clk(5);
  endtask

  task automatic walk(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) tck_step(seq[i], 1'b0);
  endtask

  task automatic test_reset;
    wait_clk(3);
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL rst_state: got %h exp 0", state); end
    checks++; if (td_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b exp 0", td_oe); end
    checks++; if (td_o !== 1'b0) begin errors++; $display("FAIL rst_tdo: got %b exp 0", td_o); end
    checks++; if ({cap_dr, shf_dr, upd_dr} !== 3'b000) begin errors++; $display("FAIL rst_strobes: got %b exp 000", {cap_dr, shf_dr, upd_dr}); end
    checks++; if ({dtmcs_sel, dmi_sel} !== 2'b00) begin errors++; $display("FAIL rst_sel: got %b exp 00", {dtmcs_sel, dmi_sel}); end
    rst_n = 1'b1;
    wait_clk(6);
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL tms5_state: got %h exp 0", state); end
    checks++; if (td_oe !== 1'b0) begin errors++; $display("FAIL tms5_oe: got %b exp 0", td_oe); end
  endtask

  task automatic test_idcode;
    logic [31:0] got;
    walk(8'b0000_0010, 4);
    checks++; if (state !== 4'h4) begin errors++; $display("FAIL idc_state: got %h exp 4", state); end
    checks++; if (td_oe !== 1'b1) begin errors++; $display("FAIL idc_oe: got %b exp 1", td_oe); end
    for (int i = 0; i < 32; i++) begin
      got[i] = td_o;
      tck_step(i == 31, 1'b0);
    end
    checks++; if (got !== 32'h1000_0CDF) begin errors++; $display("FAIL idc_stream: got %h exp 10000cdf", got); end
    checks++; if (state !== 4'h5) begin errors++; $display("FAIL idc_exit: got %h exp 5", state); end
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL tms5_from_exit1dr: got %h exp 0", state); end
  endtask

  task automatic test_ir_bypass;
    logic [4:0] got_ir;
    logic [2:0] got_dr;
    walk(8'b0000_0110, 5);
    checks++; if (state !== 4'hB) begin errors++; $display("FAIL ir_state: got %h exp b", state); end
    checks++; if (td_oe !== 1'b1) begin errors++; $display("FAIL ir_oe: got %b exp 1", td_oe); end
    for (int i = 0; i < 5; i++) begin
      got_ir[i] = td_o;
      tck_step(i == 4, 1'b1);
    end
    checks++; if (got_ir !== 5'b00001) begin errors++; $display("FAIL ir_capture_stream: got %b exp 00001", got_ir); end
    walk(8'b0000_0001, 2);
    walk(8'b0000_0010, 4);
    got_dr[0] = td_o; tck_step(1'b0, 1'b1);
    got_dr[1] = td_o; tck_step(1'b0, 1'b0);
    got_dr[2] = td_o; tck_step(1'b1, 1'b1);
    checks++; if (got_dr !== 3'b010) begin errors++; $display("FAIL bypass_stream: got %b exp 010", got_dr); end
    walk(8'b0000_0001, 2);
    checks++; if ({dtmcs_sel, dmi_sel} !== 2'b00) begin errors++; $display("FAIL bypass_sel: got %b exp 00", {dtmcs_sel, dmi_sel}); end
  endtask

  task automatic test_dmi;
    logic [7:0] pat, tdi_pat, got;
    int c0, s0, u0;
    pat     = 8'b1011_0010;
    tdi_pat = 8'b0110_1001;
    walk(8'b0000_0011, 4);
    tck_step(1'b0, 1'b1);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b0, 1'b0);
    tck_step(1'b1, 1'b1);
    walk(8'b0000_0001, 2);
    checks++; if ({dtmcs_sel, dmi_sel} !== 2'b01) begin errors++; $display("FAIL dmi_sel: got %b exp 01", {dtmcs_sel, dmi_sel}); end
    c0 = cap_cnt; s0 = shift_cnt; u0 = upd_cnt;
    dmi_tdo = pat[0];
    walk(8'b0000_0001, 3);
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL dmi_capture: got %0d exp 1", cap_cnt - c0); end
    got[0] = td_o;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) dmi_tdo = pat[i+1];
      tck_step(i == 7, tdi_pat[i]);
      if (i < 7) got[i+1] = td_o;
    end
    checks++; if (got !== pat) begin errors++; $display("FAIL dmi_tdo_stream: got %b exp %b", got, pat); end
    checks++; if (shift_cnt - s0 !== 8) begin errors++; $display("FAIL dmi_shift_count: got %0d exp 8", shift_cnt - s0); end
    checks++; if (tdi_bad !== 0) begin errors++; $display("FAIL dmi_dr_tdi: got %0d bad exp 0", tdi_bad); end
    tck_step(1'b1, 1'b0);
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL dmi_update_early: got %0d exp 0", upd_cnt - u0); end
    tck_step(1'b0, 1'b0);
    checks++; if (upd_cnt - u0 !== 1) begin errors++; $display("FAIL dmi_update: got %0d exp 1", upd_cnt - u0); end
    checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL dmi_capture_total: got %0d exp 1", cap_cnt - c0); end
  endtask

  task automatic test_rst_abort;
    int u0;
    walk(8'b0000_0010, 4);
    tck_step(1'b0, 1'b1);
    tck_step(1'b0, 1'b0);
    u0 = upd_cnt;
    rst_n = 1'b0;
    wait_clk(1);
    rst_n = 1'b1;
    wait_clk(1);
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL abort_state: got %h exp 0", state); end
    checks++; if (td_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b exp 0", td_oe); end
    checks++; if (dmi_sel !== 1'b0) begin errors++; $display("FAIL abort_ir: got dmi_sel %b exp 0", dmi_sel); end
    wait_clk(6);
    for (int i = 0; i < 3; i++) tck_step(1'b1, 1'b0);
    checks++; if (upd_cnt - u0 !== 0) begin errors++; $display("FAIL abort_no_update: got %0d exp 0", upd_cnt - u0); end
  endtask

  task automatic test_trst;
    logic [3:0] exp_state;
    walk(8'b0000_0110, 5);
    trst_n = 1'b0;
    wait_clk(SYNC + 2);
`ifdef JTAG_TAP_TRST_EN
    exp_state = 4'h0;
`else
    exp_state = 4'hB;
`endif
    checks++; if (state !== exp_state) begin errors++; $display("FAIL trst_state: got %h exp %h", state, exp_state); end
    trst_n = 1'b1;
    wait_clk(4);
    for (int i = 0; i < 5; i++) tck_step(1'b1, 1'b0);
    checks++; if (state !== 4'h0) begin errors++; $display("FAIL trst_recover: got %h exp 0", state); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_bypass();
    test_dmi();
    test_rst_abort();
    test_trst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
